// File: rtl/msrv32_pc_unit.sv
// Program counter and single-outstanding instruction fetch for the msrv32 core.
// Define MSRV32_PC_MISALIGN_CHECK_EN to flag misaligned redirects instead of aligning them.
module msrv32_pc_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        ms_riscv32_mp_clk_in,
   input  logic        ms_riscv32_mp_rst_n_in,
   input  logic        branch_taken_in,
   input  logic [6:2]  opcode_in,
   input  logic [31:0] imm_in,
   input  logic [31:0] rs1_in,
   input  logic        trap_taken_in,
   input  logic [31:0] trap_addr_in,
   input  logic        mret_in,
   input  logic [31:0] epc_in,
   input  logic        stall_in,
   output logic        imem_req_out,
   output logic [31:0] imem_addr_out,
   input  logic        imem_ack_in,
   input  logic [31:0] imem_rdata_in,
   output logic [31:0] instr_out,
   output logic        instr_valid_out,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4_out,
   output logic        misaligned_instr_out
);

   typedef enum logic [1:0] {StIdle, StReq, StValid} state_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] target_q, target_d;
   logic        flush_q, flush_d;
   logic        wait_q, wait_d;
   logic        misaligned_q, misaligned_d;

   logic        is_branch, is_jal, is_jalr;
   logic        redirect, misalign;
   logic [31:0] jump_tgt, next_pc;
   logic        flush_now;
   logic [31:0] flush_tgt;

   assign is_branch = (opcode_in == 5'b11000);
   assign is_jal    = (opcode_in == 5'b11011);
   assign is_jalr   = (opcode_in == 5'b11001);

   assign pc_plus4_out = pc_q + 32'd4;

   // Non-trap next-PC selection for the instruction leaving execute.
   always_comb begin
      redirect = 1'b1;
      jump_tgt = pc_plus4_out;
      if (mret_in) begin
         jump_tgt = epc_in;
      end else if (is_jal && branch_taken_in) begin
         jump_tgt = pc_q + imm_in;
      end else if (is_jalr && branch_taken_in) begin
         jump_tgt = (rs1_in + imm_in) & 32'hFFFF_FFFE;
      end else if (is_branch && branch_taken_in) begin
         jump_tgt = pc_q + imm_in;
      end else begin
         redirect = 1'b0;
      end
   end

`ifdef MSRV32_PC_MISALIGN_CHECK_EN
   assign next_pc  = jump_tgt;
   assign misalign = redirect && (jump_tgt[1:0] != 2'b00);
`else
   assign next_pc  = redirect ? {jump_tgt[31:2], 2'b00} : jump_tgt;
   assign misalign = 1'b0;
`endif

   // A trap always wins; an mret only lands if no redirect is already pending.
   assign flush_now = flush_q || trap_taken_in || mret_in;
   assign flush_tgt = trap_taken_in ? trap_addr_in : (flush_q ? target_q : epc_in);

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      target_d     = target_q;
      flush_d      = flush_q;
      wait_d       = wait_q;
      misaligned_d = 1'b0;
      case (state_q)
         StIdle: state_d = StReq;
         StReq: begin
            if (flush_now) begin
               flush_d  = 1'b1;
               target_d = flush_tgt;
            end
            if (imem_ack_in) begin
               if (flush_now) begin
                  // Drop the stale fetch; next cycle requests the redirect target.
                  pc_d    = flush_tgt;
                  flush_d = 1'b0;
               end else begin
                  instr_d = imem_rdata_in;
                  state_d = StValid;
               end
            end
         end
         StValid: begin
            if (trap_taken_in) begin
               pc_d    = trap_addr_in;
               wait_d  = 1'b0;
               state_d = StReq;
            end else if (!stall_in && !wait_q) begin
               if (misalign) begin
                  misaligned_d = 1'b1;
                  wait_d       = 1'b1;
               end else begin
                  pc_d    = next_pc;
                  state_d = StReq;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
      if (!ms_riscv32_mp_rst_n_in) begin
         state_q      <= StIdle;
         pc_q         <= RESET_VECTOR;
         instr_q      <= NOP;
         target_q     <= RESET_VECTOR;
         flush_q      <= 1'b0;
         wait_q       <= 1'b0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         target_q     <= target_d;
         flush_q      <= flush_d;
         wait_q       <= wait_d;
         misaligned_q <= misaligned_d;
      end
   end

   assign imem_req_out         = (state_q == StReq);
   assign imem_addr_out        = pc_q;
   assign instr_valid_out      = (state_q == StValid);
   assign instr_out            = instr_q;
   assign pc_out               = pc_q;
   assign misaligned_instr_out = misaligned_q;

endmodule

// File: tb/tb_msrv32_pc_unit.sv
// Directed self-checking bench for msrv32_pc_unit; honours MSRV32_PC_MISALIGN_CHECK_EN.
module tb_msrv32_pc_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        branch_taken = 1'b0;
   logic [6:2]  opcode = 5'b00100;
   logic [31:0] imm = 32'h0;
   logic [31:0] rs1 = 32'h0;
   logic        trap = 1'b0;
   logic [31:0] trap_addr = 32'h0;
   logic        mret = 1'b0;
   logic [31:0] epc = 32'h0;
   logic        stall = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        misaligned;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   msrv32_pc_unit dut (
      .ms_riscv32_mp_clk_in  (clk),
      .ms_riscv32_mp_rst_n_in(rst_n),
      .branch_taken_in       (branch_taken),
      .opcode_in             (opcode),
      .imm_in                (imm),
      .rs1_in                (rs1),
      .trap_taken_in         (trap),
      .trap_addr_in          (trap_addr),
      .mret_in               (mret),
      .epc_in                (epc),
      .stall_in              (stall),
      .imem_req_out          (imem_req),
      .imem_addr_out         (imem_addr),
      .imem_ack_in           (imem_ack),
      .imem_rdata_in         (imem_rdata),
      .instr_out             (instr),
      .instr_valid_out       (instr_valid),
      .pc_out                (pc),
      .pc_plus4_out          (pc_plus4),
      .misaligned_instr_out  (misaligned)
   );

   // Stimulus only: wait (bounded) for a request, then ack it for one cycle.
   task automatic fetch(input logic [31:0] rdata, output bit timed_out);
      int n = 0;
      timed_out = 1'b0;
      while (!imem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!imem_req) begin
         timed_out = 1'b1;
      end else begin
         imem_ack   = 1'b1;
         imem_rdata = rdata;
         @(negedge clk);
         imem_ack   = 1'b0;
      end
   endtask

   // Stimulus only: from VALID, trap to addr so the next request targets it.
   task automatic trap_to(input logic [31:0] addr);
      trap      = 1'b1;
      trap_addr = addr;
      @(negedge clk);
      trap      = 1'b0;
   endtask

   task automatic clear_ctrl();
      opcode       = 5'b00100;
      branch_taken = 1'b0;
      mret         = 1'b0;
      trap         = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=%h", pc, 32'h0); end
      total++; if (instr !== 32'h13) begin bad++; $display("FAIL reset_instr got=%h want=%h", instr, 32'h13); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", instr_valid); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", imem_req); end
      total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL reset_mis got=%b want=0", misaligned); end
      total++; if (pc_plus4 !== 32'h4) begin bad++; $display("FAIL reset_pc4 got=%h want=%h", pc_plus4, 32'h4); end
   endtask

   task automatic test_first_fetch();
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL first_req got=%b/%h want=1/%h", imem_req, imem_addr, 32'h0); end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL held_addr got=%b/%h want=1/%h", imem_req, imem_addr, 32'h0); end
         total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL wait_valid got=%b want=0", instr_valid); end
      end
      imem_ack = 1'b1;
      imem_rdata = 32'hAABB_CC13;
      @(negedge clk);
      imem_ack = 1'b0;
      total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b want=1", instr_valid); end
      total++; if (instr !== 32'hAABB_CC13) begin bad++; $display("FAIL first_instr got=%h want=%h", instr, 32'hAABB_CC13); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL valid_req got=%b want=0", imem_req); end
      total++; if (pc_plus4 !== 32'h4) begin bad++; $display("FAIL valid_pc4 got=%h want=%h", pc_plus4, 32'h4); end
      @(negedge clk);
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin bad++; $display("FAIL seq_fetch got=%b/%h want=1/%h", imem_req, imem_addr, 32'h4); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL req_valid got=%b want=0", instr_valid); end
   endtask

   task automatic test_trap_in_req();
      bit to;
      fetch(32'h1111_1113, to);
      total++; if (to !== 1'b0) begin bad++; $display("FAIL trq_timeout got=%b want=0", to); end
      trap_to(32'h40);
      total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL trap_valid got=%h want=%h", imem_addr, 32'h40); end
      trap = 1'b1;
      trap_addr = 32'h80;
      @(negedge clk);
      trap = 1'b0;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin bad++; $display("FAIL trq_hold got=%b/%h want=1/%h", imem_req, imem_addr, 32'h40); end
      imem_ack = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      imem_ack = 1'b0;
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL trq_discard got=%b want=0", instr_valid); end
      total++; if (instr !== 32'h1111_1113) begin bad++; $display("FAIL trq_instr got=%h want=%h", instr, 32'h1111_1113); end
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin bad++; $display("FAIL trq_target got=%b/%h want=1/%h", imem_req, imem_addr, 32'h80); end
   endtask

   task automatic test_control_flow();
      bit to;
      fetch(32'h13, to);
      trap_to(32'h100);
      fetch(32'h13, to);
      total++; if (pc !== 32'h100) begin bad++; $display("FAIL cf_pc got=%h want=%h", pc, 32'h100); end
      opcode = 5'b11000; branch_taken = 1'b1; imm = 32'hFFFF_FFF0;
      @(negedge clk);
      clear_ctrl();
      total++; if (imem_addr !== 32'hF0) begin bad++; $display("FAIL branch got=%h want=%h", imem_addr, 32'hF0); end
      fetch(32'h13, to);
      opcode = 5'b11001; branch_taken = 1'b1; rs1 = 32'h2001; imm = 32'h4;
      @(negedge clk);
      clear_ctrl();
      total++; if (imem_addr !== 32'h2004) begin bad++; $display("FAIL jalr got=%h want=%h", imem_addr, 32'h2004); end
      total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL jalr_mis got=%b want=0", misaligned); end
      fetch(32'h13, to);
      opcode = 5'b11011; branch_taken = 1'b1; imm = 32'h100;
      @(negedge clk);
      clear_ctrl();
      total++; if (imem_addr !== 32'h2104) begin bad++; $display("FAIL jal got=%h want=%h", imem_addr, 32'h2104); end
      fetch(32'h13, to);
      mret = 1'b1; epc = 32'h300; opcode = 5'b11011; branch_taken = 1'b1;
      @(negedge clk);
      clear_ctrl();
      total++; if (imem_addr !== 32'h300) begin bad++; $display("FAIL mret_prio got=%h want=%h", imem_addr, 32'h300); end
      fetch(32'h13, to);
      mret = 1'b1; epc = 32'h600; trap = 1'b1; trap_addr = 32'h500;
      @(negedge clk);
      clear_ctrl();
      total++; if (imem_addr !== 32'h500) begin bad++; $display("FAIL trap_prio got=%h want=%h", imem_addr, 32'h500); end
      total++; if (to !== 1'b0) begin bad++; $display("FAIL cf_timeout got=%b want=0", to); end
   endtask

   task automatic test_stall();
      bit to;
      fetch(32'h0050_0093, to);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++; if (pc !== 32'h500 || instr !== 32'h0050_0093) begin bad++; $display("FAIL stall_hold got=%h/%h want=%h/%h", pc, instr, 32'h500, 32'h0050_0093); end
         total++; if (imem_req !== 1'b0 || instr_valid !== 1'b1) begin bad++; $display("FAIL stall_state got=%b/%b want=0/1", imem_req, instr_valid); end
      end
      trap_to(32'h700);
      stall = 1'b0;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h700) begin bad++; $display("FAIL stall_trap got=%b/%h want=1/%h", imem_req, imem_addr, 32'h700); end
   endtask

   task automatic test_flush_same_cycle();
      imem_ack = 1'b1; imem_rdata = 32'hBAD0_0013; mret = 1'b1; epc = 32'h800;
      @(negedge clk);
      imem_ack = 1'b0;
      clear_ctrl();
      total++; if (instr_valid !== 1'b0 || imem_addr !== 32'h800) begin bad++; $display("FAIL ack_mret got=%b/%h want=0/%h", instr_valid, imem_addr, 32'h800); end
      mret = 1'b1; epc = 32'h900; trap = 1'b1; trap_addr = 32'hA00;
      @(negedge clk);
      clear_ctrl();
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      total++; if (instr_valid !== 1'b0 || imem_addr !== 32'hA00) begin bad++; $display("FAIL req_trap_mret got=%b/%h want=0/%h", instr_valid, imem_addr, 32'hA00); end
   endtask

   task automatic test_wrap();
      bit to;
      fetch(32'h13, to);
      trap_to(32'hFFFF_FFFC);
      fetch(32'h13, to);
      total++; if (pc_plus4 !== 32'h0) begin bad++; $display("FAIL wrap_pc4 got=%h want=%h", pc_plus4, 32'h0); end
      @(negedge clk);
      total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_fetch got=%h want=%h", imem_addr, 32'h0); end
   endtask

   task automatic test_misalign();
      bit to;
      fetch(32'h13, to);
      trap_to(32'h10);
      fetch(32'h13, to);
      opcode = 5'b11011; branch_taken = 1'b1; imm = 32'h6;
      @(negedge clk);
      clear_ctrl();
`ifdef MSRV32_PC_MISALIGN_CHECK_EN
      total++; if (misaligned !== 1'b1 || pc !== 32'h10) begin bad++; $display("FAIL mis_pulse got=%b/%h want=1/%h", misaligned, pc, 32'h10); end
      total++; if (imem_req !== 1'b0 || instr_valid !== 1'b1) begin bad++; $display("FAIL mis_state got=%b/%b want=0/1", imem_req, instr_valid); end
      @(negedge clk);
      total++; if (misaligned !== 1'b0 || pc !== 32'h10) begin bad++; $display("FAIL mis_once got=%b/%h want=0/%h", misaligned, pc, 32'h10); end
      trap_to(32'h20);
      total++; if (imem_addr !== 32'h20) begin bad++; $display("FAIL mis_trap got=%h want=%h", imem_addr, 32'h20); end
`else
      total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL mis_tied got=%b want=0", misaligned); end
      total++; if (imem_addr !== 32'h14) begin bad++; $display("FAIL mis_align got=%h want=%h", imem_addr, 32'h14); end
`endif
   endtask

   task automatic test_reset_mid_request();
      bit to;
      rst_n = 1'b0;
      #1;
      total++; if (imem_req !== 1'b0 || pc !== 32'h0) begin bad++; $display("FAIL async_rst got=%b/%h want=0/%h", imem_req, pc, 32'h0); end
      imem_ack = 1'b1;
      imem_rdata = 32'hFEED_0013;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (instr_valid !== 1'b0 || instr !== 32'h13) begin bad++; $display("FAIL stale_ack got=%b/%h want=0/%h", instr_valid, instr, 32'h13); end
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL rst_refetch got=%b/%h want=1/%h", imem_req, imem_addr, 32'h0); end
      imem_ack = 1'b0;
      fetch(32'h0000_0513, to);
      total++; if (instr_valid !== 1'b1 || instr !== 32'h0000_0513) begin bad++; $display("FAIL rst_fetch got=%b/%h want=1/%h", instr_valid, instr, 32'h0000_0513); end
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_trap_in_req();
      test_control_flow();
      test_stall();
      test_flush_same_cycle();
      test_wrap();
      test_misalign();
      @(negedge clk);
      test_reset_mid_request();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
